wb_gpio_debounce: RTL and testbench
===================================

Name: wb_gpio_debounce

Overview:
Wishbone slave for the board's keys, switches and LEDs, decoded at the free interconnect slot 0x7003xxxx. It synchronises and debounces raw pad inputs, latches change events into sticky flags, and raises a maskable interrupt line to the CPU interrupt vector. It also holds a CPU-writable output register that drives the LED pins.

Parameters:
clk_freq, 50000000, system clock in Hz; sets the 1 ms debounce tick.
in_width, 14, number of raw inputs (top level packs {sw[9:0], ~key_n[3:0]}); max 32.
out_width, 18, number of output bits (top level packs {ledr, ledg}); max 32.
debounce_ms, 10, ticks an input must hold a new level before it is accepted; min 1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wb_adr_i  in  32  byte address; only [4:2] decoded
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_we_i  in  1  write enable
wb_sel_i  in  4  byte lane selects
wb_ack_o  out  1  acknowledge
gpio_in  in  in_width  asynchronous raw pad inputs
gpio_out  out  out_width  registered LED drive
intr  out  1  active-high interrupt level

Behaviour:
- One clock domain (clk); reset is synchronous and active-high. Reset clears every register: wb_dat_o=0, wb_ack_o=0, gpio_out=0, intr=0, all flags, mask and counters=0, settled=0.
- Synchroniser: two flops per input, sync = stage2. Input-to-sync latency is 2 cycles.
- Prescaler: counts 0..clk_freq/1000-1. tick pulses for 1 cycle at the terminal count, then wraps to 0.
- Debounce, per bit:
  - If sync==deb, cnt<=0 on any cycle.
  - Else cnt increments on tick.
  - When an increment would reach debounce_ms: deb<=sync, cnt<=0, change event pulses for 1 cycle.
  - A glitch shorter than one tick never changes deb.
- settled:
  - Goes to 1 after debounce_ms ticks have elapsed since reset.
  - While settled=0, deb still tracks sync but change events do not set EDGE bits. This suppresses a spurious edge on inputs that are high at power-up.
- Register map (offset = adr[4:2]*4):
  - 0x00 IN: RO, deb zero-extended.
  - 0x04 OUT: RW, gpio_out.
  - 0x08 EDGE: sticky change flags. Read returns the flags. Writing 1 clears a bit; writing 0 leaves it.
  - 0x0C MASK: RW interrupt enables.
  - 0x10 RAW: RO, sync zero-extended.
  - Other offsets: read 0, writes ignored.
- Write lanes:
  - Writes honour wb_sel_i per byte.
  - Bits at or above the register width are ignored on write and read 0.
- Simultaneous events: a change event and a W1C of the same EDGE bit in the same cycle leave the bit set (set wins).
- Bus handshake:
  - Access starts when wb_stb_i&wb_cyc_i&~wb_ack_o.
  - wb_ack_o is asserted the next cycle for exactly 1 cycle, with wb_dat_o valid in that cycle.
  - Side effects (write, W1C) are applied on the cycle the access starts.
  - Back-to-back accesses therefore take 2 cycles each.
  - wb_dat_o is 0 when not acking.
- intr is registered: intr <= |(EDGE & MASK). It asserts 1 cycle after the flag sets or the mask enables, and deasserts 1 cycle after clear or mask.
- Reset mid-access: ack is dropped and the access is lost. The master must retry.

Decomposition:
- Package gpio_debounce_pkg:
  - register offset constants: REG_IN, REG_OUT, REG_EDGE, REG_MASK, REG_RAW;
  - a function for the counter width, clog2(debounce_ms+1);
  - the tick terminal-count constant.
- Sub-module debounce_cell (one per bit, generate loop):
  - inputs: clk, reset, tick, sync bit;
  - outputs: deb bit, change pulse.
- Top level holds the synchroniser, prescaler, settled logic, register file and Wishbone FSM.

Test Plan:
Benches use clk_freq=4000 (4 cycles per tick) and debounce_ms=3.
1. Reset, hold gpio_in=14'h0005 → IN reads 0x0005 once the bits have been stable for 3 ticks after settled; EDGE reads 0; intr=0.
2. After settled, raise gpio_in[4] and hold ≥16 cycles → IN bit4=1, EDGE=0x10. With MASK=0x10, intr=1 one cycle after EDGE sets.
3. Pulse gpio_in[4] for 5 cycles (<2 ticks) → IN unchanged, EDGE unchanged, intr unchanged.
4. Write EDGE=0x10 in the same cycle as a new bit4 change event → EDGE still 0x10. A later write 0x10 with no event → EDGE=0, intr drops 1 cycle later.
5. Write OUT=0x3FFFF with sel=4'b0001, then sel=4'b1111 → gpio_out=0x000FF, then 0x3FFFF. OUT readback matches; bits [31:18] read 0.
6. Read offsets 0x14 and 0x1C, and issue stb without cyc → unmapped reads return 0 with ack exactly 1 cycle wide. With stb but no cyc, no ack and no state change.

Source files
------------

// File: rtl/gpio_debounce_pkg.sv
// Shared definitions for the Wishbone GPIO debounce block: register offsets,
// bus state encoding and the counter sizing helpers.
package gpio_debounce_pkg;

  localparam logic [2:0] REG_IN   = 3'd0;
  localparam logic [2:0] REG_OUT  = 3'd1;
  localparam logic [2:0] REG_EDGE = 3'd2;
  localparam logic [2:0] REG_MASK = 3'd3;
  localparam logic [2:0] REG_RAW  = 3'd4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } wb_state_t;

  // Wide enough to hold the value debounce_ms itself.
  function automatic int cnt_width(input int ticks);
    return $clog2(ticks + 1);
  endfunction

  // Terminal count of the 1 ms prescaler.
  function automatic int tick_tc(input int freq_hz);
    return freq_hz / 1000 - 1;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One-bit debouncer: accepts a new level only after it has been held for
// debounce_ms consecutive ticks; pulses change in the accepting cycle.
module debounce_cell
  import gpio_debounce_pkg::*;
#(
  parameter int debounce_ms = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sync,
  output logic deb,
  output logic change
);

  localparam int CW = cnt_width(debounce_ms);
  localparam logic [CW-1:0] CNT_LAST = CW'(debounce_ms - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;

  always_comb begin
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    change = 1'b0;
    if (sync == deb_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CNT_LAST) begin
        deb_d  = sync;
        cnt_d  = '0;
        change = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/wb_gpio_debounce.sv
// Wishbone slave for keys/switches/LEDs: synchronise and debounce pad inputs,
// latch sticky change flags, raise a maskable interrupt, drive LED outputs.
//
// state  | meaning
// S_IDLE | no access in flight; stb&cyc starts one (side effects applied)
// S_ACK  | ack and read data presented for exactly one cycle
module wb_gpio_debounce
  import gpio_debounce_pkg::*;
#(
  parameter int clk_freq    = 50000000,
  parameter int in_width    = 14,
  parameter int out_width   = 18,
  parameter int debounce_ms = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_we_i,
  input  logic [3:0]           wb_sel_i,
  output logic                 wb_ack_o,
  input  logic [in_width-1:0]  gpio_in,
  output logic [out_width-1:0] gpio_out,
  output logic                 intr
);

  localparam int TICK_TC = tick_tc(clk_freq);
  localparam int PW      = (TICK_TC > 0) ? $clog2(TICK_TC + 1) : 1;
  localparam int CW      = cnt_width(debounce_ms);

  logic [in_width-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [PW-1:0]        pre_q, pre_d;
  logic                 tick;
  logic [CW-1:0]        settle_cnt_q, settle_cnt_d;
  logic                 settled_q, settled_d;
  logic [in_width-1:0]  deb, change;
  logic [in_width-1:0]  edge_q, edge_d, mask_q, mask_d;
  logic [out_width-1:0] out_q, out_d;
  logic [31:0]          dat_q, dat_d, rdata, be;
  logic                 intr_q, intr_d;
  wb_state_t            state_q, state_d;
  logic                 access;
  logic                 unused_adr;

  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  always_comb begin
    sync1_d = gpio_in;
    sync2_d = sync1_q;
    tick    = (pre_q == PW'(TICK_TC));
    pre_d   = tick ? '0 : pre_q + 1'b1;
  end

  // Settle timer runs once after reset so power-up levels never flag an edge.
  always_comb begin
    settle_cnt_d = settle_cnt_q;
    settled_d    = settled_q;
    if (!settled_q && tick) begin
      if (settle_cnt_q == CW'(debounce_ms - 1)) begin
        settled_d    = 1'b1;
        settle_cnt_d = '0;
      end else begin
        settle_cnt_d = settle_cnt_q + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < in_width; i++) begin : g_cell
    debounce_cell #(.debounce_ms(debounce_ms)) u_cell (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .sync  (sync2_q[i]),
      .deb   (deb[i]),
      .change(change[i])
    );
  end

  always_comb begin
    access  = wb_stb_i & wb_cyc_i & (state_q == S_IDLE);
    state_d = (state_q == S_IDLE && access) ? S_ACK : S_IDLE;
  end

  always_comb begin
    be = '0;
    for (int b = 0; b < 4; b++) be[b*8 +: 8] = {8{wb_sel_i[b]}};
  end

  always_comb begin
    rdata = '0;
    case (wb_adr_i[4:2])
      REG_IN:   rdata = 32'(deb);
      REG_OUT:  rdata = 32'(out_q);
      REG_EDGE: rdata = 32'(edge_q);
      REG_MASK: rdata = 32'(mask_q);
      REG_RAW:  rdata = 32'(sync2_q);
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    edge_d = edge_q;
    if (access && wb_we_i) begin
      case (wb_adr_i[4:2])
        REG_OUT:  out_d  = out_width'((32'(out_q) & ~be) | (wb_dat_i & be));
        REG_MASK: mask_d = in_width'((32'(mask_q) & ~be) | (wb_dat_i & be));
        REG_EDGE: edge_d = edge_q & ~in_width'(wb_dat_i & be);
        default:  ;
      endcase
    end
    // Applied after the clear so a coincident event keeps its flag.
    if (settled_q) edge_d = edge_d | change;
    dat_d  = access ? rdata : '0;
    intr_d = |(edge_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      pre_q        <= '0;
      settle_cnt_q <= '0;
      settled_q    <= 1'b0;
      edge_q       <= '0;
      mask_q       <= '0;
      out_q        <= '0;
      dat_q        <= '0;
      intr_q       <= 1'b0;
      state_q      <= S_IDLE;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      pre_q        <= pre_d;
      settle_cnt_q <= settle_cnt_d;
      settled_q    <= settled_d;
      edge_q       <= edge_d;
      mask_q       <= mask_d;
      out_q        <= out_d;
      dat_q        <= dat_d;
      intr_q       <= intr_d;
      state_q      <= state_d;
    end
  end

  assign wb_ack_o = (state_q == S_ACK);
  assign wb_dat_o = dat_q;
  assign gpio_out = out_q;
  assign intr     = intr_q;

endmodule

// File: tb/tb_wb_gpio_debounce.sv
// Self-checking bench for wb_gpio_debounce: directed sequences, a register
// vector table, and randomized traffic against a cycle-level reference model.
module tb_wb_gpio_debounce;

  localparam int IW  = 14;
  localparam int OW  = 18;
  localparam int DMS = 3;
  localparam int TPC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   wb_adr_i, wb_dat_i, wb_dat_o;
  logic          wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
  logic [3:0]    wb_sel_i;
  logic [IW-1:0] gpio_in;
  logic [OW-1:0] gpio_out;
  logic          intr;

  always #5 clk = ~clk;

  wb_gpio_debounce #(
    .clk_freq(4000), .in_width(IW), .out_width(OW), .debounce_ms(DMS)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .intr(intr)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: inputs pass two cycles of delay, ticks come every TPC
  // cycles, and a level is accepted after DMS consecutive ticks of disagreement.
  logic [IW-1:0] m_s1, m_s2, m_deb, m_edge, m_mask;
  logic [OW-1:0] m_out;
  logic [31:0]   m_dat;
  int            m_run [IW];
  int            m_phase, m_ticks;
  bit            m_settled, m_ack, m_intr;

  always @(posedge clk) begin : model
    logic [IW-1:0] ev;
    logic [31:0]   rd;
    bit            tick, start, was_settled, nxt_intr;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_edge = '0; m_mask = '0;
      m_out = '0; m_dat = '0; m_phase = 0; m_ticks = 0;
      m_settled = 0; m_ack = 0; m_intr = 0;
      for (int i = 0; i < IW; i++) m_run[i] = 0;
    end else begin
      start = wb_stb_i && wb_cyc_i && !m_ack;
      case (wb_adr_i[4:2])
        3'd0:    rd = {18'd0, m_deb};
        3'd1:    rd = {14'd0, m_out};
        3'd2:    rd = {18'd0, m_edge};
        3'd3:    rd = {18'd0, m_mask};
        3'd4:    rd = {18'd0, m_s2};
        default: rd = 32'd0;
      endcase
      nxt_intr    = |(m_edge & m_mask);
      was_settled = m_settled;
      tick        = (m_phase == TPC - 1);
      ev          = '0;
      for (int i = 0; i < IW; i++) begin
        if (m_s2[i] === m_deb[i]) m_run[i] = 0;
        else if (tick) begin
          m_run[i]++;
          if (m_run[i] == DMS) begin
            ev[i] = 1'b1; m_deb[i] = m_s2[i]; m_run[i] = 0;
          end
        end
      end
      if (tick && m_ticks < DMS) m_ticks++;
      m_settled = (m_ticks >= DMS);
      m_phase   = (m_phase + 1) % TPC;
      if (start && wb_we_i) begin
        for (int j = 0; j < 32; j++) begin
          if (wb_sel_i[j/8]) begin
            if (wb_adr_i[4:2] == 3'd1 && j < OW) m_out[j] = wb_dat_i[j];
            if (wb_adr_i[4:2] == 3'd3 && j < IW) m_mask[j] = wb_dat_i[j];
            if (wb_adr_i[4:2] == 3'd2 && j < IW && wb_dat_i[j]) m_edge[j] = 1'b0;
          end
        end
      end
      if (was_settled) m_edge = m_edge | ev;
      m_s2   = m_s1;
      m_s1   = gpio_in;
      m_ack  = start;
      m_dat  = start ? rd : 32'd0;
      m_intr = nxt_intr;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_ack", {31'd0, wb_ack_o}, {31'd0, m_ack});
      check("mon_dat", wb_dat_o, m_dat);
      check("mon_gpio_out", {14'd0, gpio_out}, {14'd0, m_out});
      check("mon_intr", {31'd0, intr}, {31'd0, m_intr});
    end
  end

  // Called at a negedge; returns at a negedge one cycle after the ack cycle.
  task automatic bus(input bit we, input logic [2:0] off, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rd);
    wb_adr_i = 32'h7003_0000 | {27'd0, off, 2'b00};
    wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(negedge clk);
    rd = wb_dat_o;
    check("ack_high", {31'd0, wb_ack_o}, 32'd1);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", {31'd0, wb_ack_o}, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  off;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
    logic [OW-1:0] exp_out;
  } vec_t;

  vec_t tbl [21];

  initial begin : main
    logic [31:0] rd;
    bit found;

    tbl[0]  = '{1, 3'd1, 32'h0003_FFFF, 4'b0001, 32'h0, 18'h000FF};
    tbl[1]  = '{0, 3'd1, 32'h0,         4'b1111, 32'h0000_00FF, 18'h000FF};
    tbl[2]  = '{1, 3'd1, 32'h0003_FFFF, 4'b1111, 32'h0, 18'h3FFFF};
    tbl[3]  = '{0, 3'd1, 32'h0,         4'b1111, 32'h0003_FFFF, 18'h3FFFF};
    tbl[4]  = '{1, 3'd1, 32'h1234_5678, 4'b0110, 32'h0, 18'h056FF};
    tbl[5]  = '{0, 3'd1, 32'h0,         4'b1111, 32'h0000_56FF, 18'h056FF};
    tbl[6]  = '{0, 3'd5, 32'h0,         4'b1111, 32'h0, 18'h056FF};
    tbl[7]  = '{0, 3'd7, 32'h0,         4'b1111, 32'h0, 18'h056FF};
    tbl[8]  = '{1, 3'd3, 32'hFFFF_FFFF, 4'b0001, 32'h0, 18'h056FF};
    tbl[9]  = '{0, 3'd3, 32'h0,         4'b1111, 32'h0000_00FF, 18'h056FF};
    tbl[10] = '{1, 3'd0, 32'h0000_FFFF, 4'b1111, 32'h0, 18'h056FF};
    tbl[11] = '{0, 3'd0, 32'h0,         4'b1111, 32'h0000_0005, 18'h056FF};
    tbl[12] = '{0, 3'd4, 32'h0,         4'b1111, 32'h0000_0005, 18'h056FF};
    tbl[13] = '{1, 3'd6, 32'hFFFF_FFFF, 4'b1111, 32'h0, 18'h056FF};
    tbl[14] = '{0, 3'd1, 32'h0,         4'b1111, 32'h0000_56FF, 18'h056FF};
    tbl[15] = '{1, 3'd3, 32'hFFFF_FFFF, 4'b1111, 32'h0, 18'h056FF};
    tbl[16] = '{0, 3'd3, 32'h0,         4'b1111, 32'h0000_3FFF, 18'h056FF};
    tbl[17] = '{1, 3'd3, 32'h0000_0010, 4'b1111, 32'h0, 18'h056FF};
    tbl[18] = '{0, 3'd3, 32'h0,         4'b1111, 32'h0000_0010, 18'h056FF};
    tbl[19] = '{1, 3'd2, 32'hFFFF_FFFF, 4'b1111, 32'h0, 18'h056FF};
    tbl[20] = '{0, 3'd2, 32'h0,         4'b1111, 32'h0, 18'h056FF};

    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
    gpio_in = 14'h0005;
    reset = 1'b1;
    idle(3);
    mon_en = 1'b1;
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_gpio_out", {14'd0, gpio_out}, 32'd0);
    check("rst_intr", {31'd0, intr}, 32'd0);
    reset = 1'b0;
    idle(40);

    // power-up level accepted without flagging an edge
    bus(0, 3'd0, 0, 4'hF, rd); check("init_in", rd, 32'h5);
    bus(0, 3'd2, 0, 4'hF, rd); check("init_edge", rd, 32'h0);
    check("init_intr", {31'd0, intr}, 32'd0);

    // rising bit4 sets EDGE and, with MASK, the interrupt
    bus(1, 3'd3, 32'h10, 4'hF, rd);
    gpio_in = 14'h0015;
    idle(20);
    check("rise_intr", {31'd0, intr}, 32'd1);
    bus(0, 3'd0, 0, 4'hF, rd); check("rise_in", rd, 32'h15);
    bus(0, 3'd2, 0, 4'hF, rd); check("rise_edge", rd, 32'h10);

    // short glitch is ignored
    gpio_in = 14'h0005;
    idle(5);
    gpio_in = 14'h0015;
    idle(20);
    bus(0, 3'd0, 0, 4'hF, rd); check("glitch_in", rd, 32'h15);
    bus(0, 3'd2, 0, 4'hF, rd); check("glitch_edge", rd, 32'h10);
    check("glitch_intr", {31'd0, intr}, 32'd1);

    // W1C coincident with a change event: set wins
    gpio_in = 14'h0005;
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (m_phase == TPC - 1 && m_run[4] == DMS - 1 && m_s2[4] !== m_deb[4]) found = 1;
      else @(negedge clk);
    end
    check("w1c_collide_found", {31'd0, found}, 32'd1);
    bus(1, 3'd2, 32'h10, 4'hF, rd);
    bus(0, 3'd2, 0, 4'hF, rd); check("w1c_collide_edge", rd, 32'h10);
    bus(0, 3'd0, 0, 4'hF, rd); check("fall_in", rd, 32'h5);

    wb_adr_i = 32'h7003_0008; wb_dat_i = 32'h10; wb_sel_i = 4'hF;
    wb_we_i = 1; wb_stb_i = 1; wb_cyc_i = 1;
    @(negedge clk);
    check("w1c_ack", {31'd0, wb_ack_o}, 32'd1);
    check("w1c_intr_hold", {31'd0, intr}, 32'd1);
    wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
    @(negedge clk);
    check("w1c_intr_drop", {31'd0, intr}, 32'd0);
    bus(0, 3'd2, 0, 4'hF, rd); check("w1c_edge_clear", rd, 32'h0);

    foreach (tbl[i]) begin
      bus(tbl[i].we, tbl[i].off, tbl[i].dat, tbl[i].sel, rd);
      if (!tbl[i].we) check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_out", i), {14'd0, gpio_out}, {14'd0, tbl[i].exp_out});
    end

    // strobe without cycle must be ignored
    wb_adr_i = 32'h7003_0004; wb_dat_i = 32'h0; wb_sel_i = 4'hF;
    wb_we_i = 1; wb_stb_i = 1; wb_cyc_i = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("nocyc_ack", {31'd0, wb_ack_o}, 32'd0);
    end
    wb_stb_i = 0; wb_we_i = 0;
    @(negedge clk);
    check("nocyc_out", {14'd0, gpio_out}, 32'h056FF);

    // randomized traffic, checked every cycle by the monitor
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 3))
        0: begin gpio_in = IW'($urandom); idle($urandom_range(0, 30)); end
        1: begin
          gpio_in = gpio_in ^ IW'(1 << $urandom_range(0, IW - 1));
          idle($urandom_range(1, 6));
          gpio_in = gpio_in ^ IW'(1 << $urandom_range(0, IW - 1));
        end
        default: ;
      endcase
      bus(1'($urandom), 3'($urandom_range(0, 7)), $urandom, 4'($urandom), rd);
      idle($urandom_range(0, 3));
    end

    // reset during an ack cycle drops the ack
    wb_adr_i = 32'h7003_0000; wb_we_i = 0; wb_stb_i = 1; wb_cyc_i = 1;
    @(negedge clk);
    check("midrst_ack_before", {31'd0, wb_ack_o}, 32'd1);
    reset = 1; wb_stb_i = 0; wb_cyc_i = 0;
    @(negedge clk);
    check("midrst_ack_after", {31'd0, wb_ack_o}, 32'd0);
    check("midrst_out", {14'd0, gpio_out}, 32'd0);
    reset = 0;
    idle(30);
    bus(0, 3'd2, 0, 4'hF, rd); check("midrst_edge", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
